// File: rtl/mem_arbiter.sv
// Two-requester RAM arbiter: data normally wins, but an instruction fetch that
// has watched STARVE_MAX consecutive data grants gets the next grant.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  localparam int CW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
  localparam logic [CW-1:0] STARVE_LIMIT = CW'(STARVE_MAX);
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

  state_t        state, next_state;
  logic [CW-1:0] starve_cnt;
  logic          dreq, ram_acc, i_done, d_done;

  assign dreq    = dREN | dWEN;
  assign ram_acc = (ramstate == RAM_ACCESS);
  // A completion needs the owner still requesting; a dropped request just releases the RAM.
  assign i_done  = (state == IACC) && iREN && ram_acc;
  assign d_done  = (state == DACC) && dreq && ram_acc;

  assign iwait = iREN & ~((state == IACC) & ram_acc);
  assign dwait = dreq & ~((state == DACC) & ram_acc);
  assign iload = i_done ? ramload : '0;
  assign dload = d_done ? ramload : '0;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state <= next_state;
      if (!iREN || i_done) begin
        starve_cnt <= '0;
      end else if (d_done && starve_cnt < STARVE_LIMIT) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  // NOTE: every output is given a default first so no path through the case infers a latch.
  always_comb begin
    next_state = state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    unique case (state)
      IDLE: begin
        if (dreq && starve_cnt < STARVE_LIMIT) next_state = DACC;
        else if (iREN)                         next_state = IACC;
        else if (dreq)                         next_state = DACC;
      end
      IACC: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (!iREN || ram_acc) next_state = IDLE;
      end
      DACC: begin
        ramaddr  = daddr;
        ramstore = dstore;
        // A simultaneous read and write is treated as a write only.
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (!dreq || ram_acc) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_MAX, default 4: maximum consecutive data grants while an instruction request waits.
REQ-002 The block SHALL have port CLK  input  1  system clock; all state updates on rising edge.
REQ-003 The block SHALL have port nRST  input  1  reset, synchronous and active-low, sampled on rising CLK.
REQ-004 The block SHALL have port iREN  input  1  instruction read request.
REQ-005 The block SHALL have port iaddr  input  32  instruction word address.
REQ-006 The block SHALL have port iwait  output  1  instruction request not yet complete.
REQ-007 The block SHALL have port iload  output  32  instruction read data.
REQ-008 The block SHALL have port dREN  input  1  data read request.
REQ-009 The block SHALL have port dWEN  input  1  data write request.
REQ-010 The block SHALL have port daddr  input  32  data address.
REQ-011 The block SHALL have port dstore  input  32  data write value.
REQ-012 The block SHALL have port dwait  output  1  data request not yet complete.
REQ-013 The block SHALL have port dload  output  32  data read data.
REQ-014 The block SHALL have ports ramREN, ramWEN  output  1 each  RAM read and write strobes.
REQ-015 The block SHALL have ports ramaddr, ramstore  output  32 each  RAM address and write data.
REQ-016 The block SHALL have ports ramload  input  32  RAM read data; ramstate  input  2  RAM status (0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR).

Function
REQ-017 The FSM SHALL have three states: IDLE, IACC (instruction owns RAM), DACC (data owns RAM).
REQ-018 In IDLE the block SHALL drive ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
REQ-019 From IDLE, if (dREN|dWEN) and starve_cnt<STARVE_MAX, the next state SHALL be DACC; else if iREN, IACC; else if (dREN|dWEN), DACC; else IDLE.
REQ-020 In IACC the block SHALL drive ramREN=1, ramaddr=iaddr, ramWEN=0.
REQ-021 In DACC the block SHALL drive ramaddr=daddr and ramstore=dstore; if dWEN, ramWEN=1 and ramREN=0; else ramREN=dREN.
REQ-022 When dWEN and dREN are both high, the write SHALL take precedence and the read SHALL be ignored.
REQ-023 Completion SHALL be the cycle in xACC with ramstate==ACCESS: the owner's wait drops to 0 that cycle, its load equals ramload, and the FSM returns to IDLE at the next edge.
REQ-024 iwait SHALL equal iREN & !(IACC & ramstate==ACCESS); dwait SHALL equal (dREN|dWEN) & !(DACC & ramstate==ACCESS).
REQ-025 iload and dload SHALL be 0 outside their completion cycle.
REQ-026 ramstate BUSY, FREE or ERROR in xACC SHALL hold state and RAM outputs (automatic retry); no timeout.
REQ-027 If the owning requester deasserts its request in xACC, the FSM SHALL return to IDLE at the next edge with no completion.
REQ-028 starve_cnt (3 bits minimum, saturating at STARVE_MAX) SHALL increment on each data completion while iREN=1, clear on instruction completion, and clear in any cycle with iREN=0.
REQ-029 Minimum access latency SHALL be 2 cycles (IDLE grant edge, then ACCESS in first xACC cycle).

Reset
REQ-030 While nRST=0 at a rising edge, state SHALL become IDLE and starve_cnt 0, regardless of any in-progress access.
REQ-031 During and after reset all outputs SHALL take their IDLE values; iwait/dwait follow REQ-024.

Verification
REQ-032 iREN=1, iaddr=0x40, ramstate=ACCESS with ramload=0x8C010004 -> IACC next cycle, iwait=0 and iload=0x8C010004 that cycle, IDLE after.
REQ-033 iREN=1 and dWEN=1 (daddr=0x100, dstore=0xDEADBEEF) together from IDLE -> DACC first, ramWEN=1, ramaddr=0x100; IACC only after data completion.
REQ-034 iREN held, data requests back-to-back, ramstate always ACCESS -> exactly 4 data grants, then one IACC grant, starve_cnt clears to 0.
REQ-035 DACC with ramstate=BUSY for 3 cycles then ACCESS -> RAM outputs stable, dwait=1 for 3 cycles, completion on cycle 4.
REQ-036 nRST=0 asserted mid-IACC -> next edge IDLE, ramREN=0, starve_cnt=0; new request after release re-arbitrated normally.
